// File: rtl/decode_stage.sv
// decode_stage: registered, flow-controlled instruction decode stage.
// Accepts one fetched word per cycle (valid/ready), folds an immediate-extension
// prefix word into the next instruction's immediate, and buffers decoded
// instructions in a circular FIFO drained by issue with valid/yumi.
// Decoded entry layout (MSB..LSB):
//   {w_v, opcode[4:0], func_unit[1:0], flags[1:0], dest_id, source_1, source2_imm, bcc_op[3:0]}
module decode_stage #(
    parameter int         WORD_SIZE_P  = 16,
    parameter int         NUM_REG      = 16,
    parameter int         PC_WIDTH_P   = 16,
    parameter int         FIFO_DEPTH_P = 2,
    parameter logic [4:0] PREFIX_OP_P  = 5'b11110,
    localparam int REG_ID_W = $clog2(NUM_REG),
    localparam int DECODED_INSTRUCTION_WIDTH = 1 + 5 + 2 + 2 + 2 * REG_ID_W + WORD_SIZE_P + 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 flush_i,
    input  logic                                 inst_v_i,
    input  logic [WORD_SIZE_P-1:0]               inst_i,
    input  logic [PC_WIDTH_P-1:0]                pc_i,
    output logic                                 inst_ready_o,
    output logic                                 v_o,
    output logic [DECODED_INSTRUCTION_WIDTH-1:0] o,
    output logic                                 ext_v_o,
    output logic [PC_WIDTH_P-1:0]                pc_o,
    input  logic                                 yumi_i
);

    localparam int PTR_W = (FIFO_DEPTH_P > 1) ? $clog2(FIFO_DEPTH_P) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH_P + 1);
    localparam int P_W   = WORD_SIZE_P - 5;

    localparam logic [1:0] SRC2_REG   = 2'd0;
    localparam logic [1:0] SRC2_IMM5Z = 2'd1;
    localparam logic [1:0] SRC2_IMM5S = 2'd2;
    localparam logic [1:0] SRC2_IMM8Z = 2'd3;

    // Microcode ROM word: {w_v, func_unit[1:0], flags[1:0], dest_link, src1_zero, src2_sel[1:0]}
    function automatic logic [8:0] rom_lookup(input logic [4:0] op);
        logic [8:0] word;
        case (op[4:2])
            3'd0, 3'd1: word = {1'b1, 2'd0, 2'b01, 1'b0, 1'b0, SRC2_REG};
            3'd2:       word = {1'b1, 2'd0, 2'b01, 1'b0, 1'b0, SRC2_IMM5Z};
            3'd3: begin
                if (op[1]) begin
                    word = {1'b1, 2'd0, 2'b01, 1'b0, 1'b0, SRC2_IMM8Z};
                end else begin
                    word = {1'b1, 2'd0, 2'b01, 1'b0, 1'b0, SRC2_IMM5S};
                end
            end
            3'd4:       word = {1'b1, 2'd1, 2'b00, 1'b0, 1'b0, SRC2_IMM5S};
            3'd5:       word = {1'b0, 2'd1, 2'b00, 1'b0, 1'b0, SRC2_IMM5Z};
            3'd6:       word = {1'b0, 2'd2, 2'b10, 1'b0, 1'b1, SRC2_IMM8Z};
            3'd7: begin
                case (op[1:0])
                    2'd0:    word = {1'b1, 2'd2, 2'b00, 1'b1, 1'b1, SRC2_IMM8Z};
                    2'd3:    word = {1'b0, 2'd3, 2'b11, 1'b0, 1'b1, SRC2_REG};
                    default: word = {1'b0, 2'd3, 2'b00, 1'b0, 1'b1, SRC2_REG};
                endcase
            end
            default:    word = {1'b0, 2'd3, 2'b00, 1'b0, 1'b1, SRC2_REG};
        endcase
        return word;
    endfunction

    // Circular pointer advance, wrapping to zero after the last entry
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(FIFO_DEPTH_P - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    logic [4:0]                           opcode_s;
    logic                                 is_prefix_s;
    logic [8:0]                           rom_s;
    logic [1:0]                           src2_sel_s;
    logic [REG_ID_W-1:0]                  dest_s;
    logic [REG_ID_W-1:0]                  src1_s;
    logic [WORD_SIZE_P-1:0]               src2_mux_s;
    logic [WORD_SIZE_P-1:0]               src2_s;
    logic                                 ext_s;
    logic [DECODED_INSTRUCTION_WIDTH-1:0] decoded_s;
    logic                                 accept_s;
    logic                                 enq_s;
    logic                                 deq_s;

    logic                                 pending_r;
    logic [P_W-1:0]                       prefix_r;
    logic [PTR_W-1:0]                     rd_ptr_r;
    logic [PTR_W-1:0]                     wr_ptr_r;
    logic [CNT_W-1:0]                     count_r;
    logic [DECODED_INSTRUCTION_WIDTH-1:0] mem_r     [FIFO_DEPTH_P];
    logic                                 ext_mem_r [FIFO_DEPTH_P];
    logic [PC_WIDTH_P-1:0]                pc_mem_r  [FIFO_DEPTH_P];

    assign opcode_s    = inst_i[WORD_SIZE_P-1 -: 5];
    assign is_prefix_s = (opcode_s == PREFIX_OP_P);

    // Ready depends only on occupancy so there is no combinational yumi->ready path
    assign inst_ready_o = (count_r < CNT_W'(FIFO_DEPTH_P));
    assign v_o          = (count_r != {CNT_W{1'b0}});
    assign accept_s     = inst_v_i & inst_ready_o & ~flush_i;
    assign enq_s        = accept_s & ~is_prefix_s;
    assign deq_s        = yumi_i & v_o & ~flush_i;

    // Head outputs come straight from FIFO storage
    assign o       = mem_r[rd_ptr_r];
    assign ext_v_o = ext_mem_r[rd_ptr_r];
    assign pc_o    = pc_mem_r[rd_ptr_r];

    // Field extraction, operand muxing and prefix folding of the incoming word
    always_comb begin
        rom_s      = rom_lookup(opcode_s);
        src2_sel_s = rom_s[1:0];
        dest_s     = rom_s[3] ? REG_ID_W'(NUM_REG - 1) : inst_i[8 +: REG_ID_W];
        src1_s     = rom_s[2] ? {REG_ID_W{1'b0}} : inst_i[4 +: REG_ID_W];
        case (src2_sel_s)
            SRC2_REG:   src2_mux_s = {{(WORD_SIZE_P-REG_ID_W){1'b0}}, inst_i[REG_ID_W-1:0]};
            SRC2_IMM5Z: src2_mux_s = {{(WORD_SIZE_P-5){1'b0}}, inst_i[4:0]};
            SRC2_IMM5S: src2_mux_s = {{(WORD_SIZE_P-5){inst_i[4]}}, inst_i[4:0]};
            SRC2_IMM8Z: src2_mux_s = {{(WORD_SIZE_P-8){1'b0}}, inst_i[7:0]};
            default:    src2_mux_s = {WORD_SIZE_P{1'b0}};
        endcase
        // A pending prefix only matters when the ROM picks an immediate source
        if (pending_r && (src2_sel_s != SRC2_REG)) begin
            src2_s = {prefix_r, inst_i[4:0]};
            ext_s  = 1'b1;
        end else begin
            src2_s = src2_mux_s;
            ext_s  = 1'b0;
        end
        decoded_s = {rom_s[8], opcode_s, rom_s[7:6], rom_s[5:4], dest_s, src1_s, src2_s, inst_i[11:8]};
    end

    // Prefix state, FIFO pointers and occupancy count
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pending_r <= 1'b0;
            prefix_r  <= {P_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            wr_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            pending_r <= 1'b0;
            rd_ptr_r  <= {PTR_W{1'b0}};
            wr_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
        end else begin
            if (accept_s && is_prefix_s) begin
                pending_r <= 1'b1;
                prefix_r  <= inst_i[P_W-1:0];
            end else if (enq_s) begin
                pending_r <= 1'b0;
            end
            if (enq_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (deq_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage: cleared on reset, written at the tail on enqueue
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < FIFO_DEPTH_P; i++) begin
                mem_r[i]     <= {DECODED_INSTRUCTION_WIDTH{1'b0}};
                ext_mem_r[i] <= 1'b0;
                pc_mem_r[i]  <= {PC_WIDTH_P{1'b0}};
            end
        end else if (enq_s) begin
            mem_r[wr_ptr_r]     <= decoded_s;
            ext_mem_r[wr_ptr_r] <= ext_s;
            pc_mem_r[wr_ptr_r]  <= pc_i;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table, directed prefix,
// full, flush and reset sequences, and randomized traffic against a queue model.
module tb_decode_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        flush = 1'b0;
    logic        inst_v = 1'b0;
    logic [15:0] inst = 16'h0000;
    logic [15:0] pc_in = 16'h0000;
    logic        yumi = 1'b0;
    logic        ready;
    logic        v;
    logic [37:0] o;
    logic        ext_v;
    logic [15:0] pc_out;

    always #5 clk = ~clk;

    decode_stage #(.FIFO_DEPTH_P(DEPTH)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .inst_v_i(inst_v),
        .inst_i(inst), .pc_i(pc_in), .inst_ready_o(ready), .v_o(v), .o(o),
        .ext_v_o(ext_v), .pc_o(pc_out), .yumi_i(yumi)
    );

    typedef struct { logic [37:0] dec; logic ext; logic [15:0] pc; } entry_t;
    typedef struct { logic [15:0] inst; logic [37:0] exp_o; } vec_t;

    entry_t      q[$];
    logic        pend_m = 1'b0;
    logic [10:0] pfx_m = 11'h000;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] mk(input logic wv, input int op, input int fu, input int fl,
                                       input int dst, input int s1, input int s2, input int bcc);
        return {wv, 5'(op), 2'(fu), 2'(fl), 4'(dst), 4'(s1), 16'(s2), 4'(bcc)};
    endfunction

    // Behavioural decode: opcode ranges -> unit, flags and operand kind; returns {ext, entry}
    function automatic logic [38:0] ref_decode(input logic [15:0] w, input logic pend, input logic [10:0] p);
        int          op;
        logic        wv, imm, ext;
        logic [1:0]  fu, fl;
        logic [3:0]  dst, s1;
        logic [15:0] s2, z5, s5, z8;
        op  = int'(w[15:11]);
        z5  = {11'h000, w[4:0]};
        s5  = {{11{w[4]}}, w[4:0]};
        z8  = {8'h00, w[7:0]};
        dst = w[11:8];
        s1  = w[7:4];
        s2  = {12'h000, w[3:0]};
        imm = 1'b0; wv = 1'b0; fu = 2'd0; fl = 2'd0;
        if (op < 8) begin
            wv = 1'b1; fl = 2'd1;
        end else if (op < 16) begin
            wv = 1'b1; fl = 2'd1; imm = 1'b1;
            s2 = (op < 12) ? z5 : ((op < 14) ? s5 : z8);
        end else if (op < 20) begin
            wv = 1'b1; fu = 2'd1; imm = 1'b1; s2 = s5;
        end else if (op < 24) begin
            fu = 2'd1; imm = 1'b1; s2 = z5;
        end else if (op < 28) begin
            fu = 2'd2; fl = 2'd2; s1 = 4'd0; imm = 1'b1; s2 = z8;
        end else if (op == 28) begin
            wv = 1'b1; fu = 2'd2; dst = 4'd15; s1 = 4'd0; imm = 1'b1; s2 = z8;
        end else begin
            fu = 2'd3; s1 = 4'd0; fl = (op == 31) ? 2'd3 : 2'd0;
        end
        ext = pend && imm;
        if (ext) s2 = {p, w[4:0]};
        return {ext, wv, w[15:11], fu, fl, dst, s1, s2, w[11:8]};
    endfunction

    // Advance the reference model by one clock edge using the currently driven inputs
    task automatic model_edge();
        logic       acc, deq;
        logic [38:0] r;
        entry_t     e;
        if (!flush) begin
            acc = inst_v && (q.size() < DEPTH);
            deq = yumi && (q.size() != 0);
            if (deq) void'(q.pop_front());
            if (acc) begin
                if (inst[15:11] == 5'b11110) begin
                    pend_m = 1'b1;
                    pfx_m  = inst[10:0];
                end else begin
                    r = ref_decode(inst, pend_m, pfx_m);
                    e.dec = r[37:0]; e.ext = r[38]; e.pc = pc_in;
                    q.push_back(e);
                    pend_m = 1'b0;
                end
            end
        end else begin
            q.delete();
            pend_m = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_v"}, 64'(v), 64'(q.size() != 0));
        chk({tag, "_ready"}, 64'(ready), 64'(q.size() < DEPTH));
        if (q.size() != 0) begin
            chk({tag, "_o"}, 64'(o), 64'(q[0].dec));
            chk({tag, "_ext"}, 64'(ext_v), 64'(q[0].ext));
            chk({tag, "_pc"}, 64'(pc_out), 64'(q[0].pc));
        end
    endtask

    // One clock: drive inputs, check at the falling edge, step model, return at posedge+1
    task automatic cycle(input string tag, input logic iv, input logic [15:0] w,
                         input logic [15:0] p, input logic y, input logic f);
        inst_v = iv; inst = w; pc_in = p; yumi = y; flush = f;
        @(negedge clk);
        check_outputs(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_v"}, 64'(v), 64'd0);
        chk({tag, "_ready"}, 64'(ready), 64'd1);
        chk({tag, "_o"}, 64'(o), 64'd0);
        chk({tag, "_ext"}, 64'(ext_v), 64'd0);
        chk({tag, "_pc"}, 64'(pc_out), 64'd0);
    endtask

    task automatic apply_reset(input string tag);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inst_v = 1'($urandom); inst = 16'($urandom); pc_in = 16'($urandom);
            yumi = 1'($urandom); flush = 1'($urandom);
            #2;
            check_zero(tag);
            @(posedge clk);
            #1;
        end
        q.delete(); pend_m = 1'b0; pfx_m = 11'h000;
        inst_v = 1'b0; yumi = 1'b0; flush = 1'b0;
        reset_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_plain();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:11] == 5'b11110) w[15:11] = 5'd3;
        return w;
    endfunction

    vec_t tbl[10];

    initial begin
        tbl[0] = '{16'h1B21, mk(1'b1,  3, 0, 1, 11,  2, 16'h0001, 11)};
        tbl[1] = '{16'h4C37, mk(1'b1,  9, 0, 1, 12,  3, 16'h0017, 12)};
        tbl[2] = '{16'h6A5B, mk(1'b1, 13, 0, 1, 10,  5, 16'hFFFB, 10)};
        tbl[3] = '{16'h7CE4, mk(1'b1, 15, 0, 1, 12, 14, 16'h00E4, 12)};
        tbl[4] = '{16'h8D90, mk(1'b1, 17, 1, 0, 13,  9, 16'hFFF0, 13)};
        tbl[5] = '{16'hAA3F, mk(1'b0, 21, 1, 0, 10,  3, 16'h001F, 10)};
        tbl[6] = '{16'hCB7A, mk(1'b0, 25, 2, 2, 11,  0, 16'h007A, 11)};
        tbl[7] = '{16'hE345, mk(1'b1, 28, 2, 0, 15,  0, 16'h0045,  3)};
        tbl[8] = '{16'hE9AB, mk(1'b0, 29, 3, 0,  9,  0, 16'h000B,  9)};
        tbl[9] = '{16'hFF12, mk(1'b0, 31, 3, 3, 15,  0, 16'h0002, 15)};

        #1;
        apply_reset("rst");
        @(negedge clk);
        check_zero("rst_rel");
        @(posedge clk);
        #1;

        // Decode table through an empty FIFO
        for (int i = 0; i < 10; i++) begin
            cycle("tbl_in", 1'b1, tbl[i].inst, 16'(i * 2), 1'b0, 1'b0);
            chk("tbl_o", 64'(o), 64'(tbl[i].exp_o));
            chk("tbl_ext", 64'(ext_v), 64'd0);
            cycle("tbl_drain", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        end

        // Streaming at full rate with yumi held high
        for (int i = 0; i < 8; i++) begin
            cycle("stream", 1'b1, rand_plain(), 16'(i * 2), 1'b1, 1'b0);
            chk("stream_v", 64'(v), 64'd1);
            chk("stream_pc", 64'(pc_out), 64'(i * 2));
        end
        cycle("stream_end", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

        // Prefix extension of an imm_5z instruction
        cycle("pfx1", 1'b1, 16'hF7FF, 16'h0010, 1'b0, 1'b0);
        chk("pfx1_noentry", 64'(v), 64'd0);
        cycle("pfx1", 1'b1, 16'h4C35, 16'h0012, 1'b0, 1'b0);
        chk("pfx1_imm", 64'(o[19:4]), 64'hFFF5);
        chk("pfx1_ext", 64'(ext_v), 64'd1);
        chk("pfx1_pc", 64'(pc_out), 64'h0012);
        cycle("pfx1", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        chk("pfx1_single", 64'(v), 64'd0);

        // Last prefix wins, then an unprefixed immediate
        cycle("pfx2", 1'b1, 16'hF001, 16'h0014, 1'b0, 1'b0);
        cycle("pfx2", 1'b1, 16'hF002, 16'h0016, 1'b0, 1'b0);
        cycle("pfx2", 1'b1, 16'h4C23, 16'h0018, 1'b0, 1'b0);
        chk("pfx2_imm", 64'(o[19:4]), 64'h0043);
        chk("pfx2_ext", 64'(ext_v), 64'd1);
        cycle("pfx2", 1'b1, 16'h4C23, 16'h001A, 1'b1, 1'b0);
        chk("nopfx_imm", 64'(o[19:4]), 64'h0003);
        chk("nopfx_ext", 64'(ext_v), 64'd0);
        cycle("pfx2", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

        // Full FIFO backpressure and pointer wrap
        for (int i = 0; i < 4; i++) begin
            cycle("full", 1'b1, rand_plain(), 16'(16'h0020 + i * 2), 1'b0, 1'b0);
        end
        chk("full_ready", 64'(ready), 64'd0);
        chk("full_head", 64'(pc_out), 64'h0020);
        cycle("full", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        chk("full_reready", 64'(ready), 64'd1);
        cycle("full", 1'b1, rand_plain(), 16'h0024, 1'b0, 1'b0);
        cycle("full", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        chk("wrap_order", 64'(pc_out), 64'h0024);
        cycle("full", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        chk("wrap_empty", 64'(v), 64'd0);

        // Flush with a buffered entry and a pending prefix, accept and yumi both high
        cycle("flush", 1'b1, rand_plain(), 16'h0030, 1'b0, 1'b0);
        cycle("flush", 1'b1, 16'hF155, 16'h0032, 1'b0, 1'b0);
        cycle("flush", 1'b1, 16'h4C23, 16'h0034, 1'b1, 1'b1);
        chk("flush_v", 64'(v), 64'd0);
        chk("flush_ready", 64'(ready), 64'd1);
        cycle("flush", 1'b1, 16'h4C23, 16'h0036, 1'b0, 1'b0);
        chk("flush_ext", 64'(ext_v), 64'd0);
        chk("flush_imm", 64'(o[19:4]), 64'h0003);
        cycle("flush", 1'b1, rand_plain(), 16'h0038, 1'b0, 1'b0);
        cycle("flush_full", 1'b1, rand_plain(), 16'h003A, 1'b1, 1'b1);
        chk("flush_full_v", 64'(v), 64'd0);

        // Asynchronous reset in the middle of traffic
        cycle("mrst", 1'b1, rand_plain(), 16'h0040, 1'b0, 1'b0);
        cycle("mrst", 1'b1, 16'hF3AA, 16'h0042, 1'b0, 1'b0);
        inst_v = 1'b1; inst = 16'h4C23; yumi = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("mrst_low");
        q.delete(); pend_m = 1'b0; pfx_m = 11'h000;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle("mrst", 1'b1, 16'h4C23, 16'h0044, 1'b0, 1'b0);
        chk("mrst_ext", 64'(ext_v), 64'd0);
        chk("mrst_imm", 64'(o[19:4]), 64'h0003);
        cycle("mrst", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] w;
            logic        iv, y, f;
            w  = ($urandom_range(0, 4) == 0) ? (16'hF000 | 16'($urandom_range(0, 2047))) : 16'($urandom);
            iv = ($urandom_range(0, 3) != 0);
            y  = ($urandom_range(0, 2) != 0) && (q.size() != 0);
            f  = ($urandom_range(0, 24) == 0);
            cycle("rand", iv, w, 16'($urandom) & 16'hFFFE, y, f);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle("final", 1'b0, 16'h0000, 16'h0000, (q.size() != 0), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled instruction decode stage that replaces the purely combinational decoder at the front-end/back-end boundary. It accepts one fetched word per cycle under a valid/ready handshake. It folds an immediate-extension prefix word into the following instruction's immediate, and it buffers decoded instructions in a parametrised FIFO that issue drains with valid/yumi. Field extraction uses the existing microcode ROM and operand multiplexers unchanged. This block adds the sequencing, prefix state and buffering around them.

## Interface
- WORD_SIZE_P, 16, instruction and data word width (≥ 8)
- NUM_REG, 16, architectural registers; register ids are $clog2(NUM_REG) bits
- PC_WIDTH_P, 16, width of the fetch PC carried alongside each instruction
- FIFO_DEPTH_P, 2, decoded-instruction buffer entries (≥ 2)
- PREFIX_OP_P, 5'b11110, value of inst_i[WORD_SIZE_P-1 -: 5] that marks a prefix word
- clk_i  in  1  clock; single clock domain
- reset_n_i  in  1  asynchronous, active-low reset
- flush_i  in  1  discard all buffered entries and pending prefix state
- inst_v_i  in  1  inst_i and pc_i valid
- inst_i  in  WORD_SIZE_P  fetched instruction word
- pc_i  in  PC_WIDTH_P  PC of inst_i
- inst_ready_o  out  1  stage can accept a word this cycle
- v_o  out  1  head of the FIFO is a valid decoded instruction
- o  out  DECODED_INSTRUCTION_WIDTH  decoded head entry (w_v, opcode, func_unit, flags, dest_id, source_1, source2_imm, bcc_op)
- ext_v_o  out  1  head entry's source2_imm was extended by a prefix
- pc_o  out  PC_WIDTH_P  PC of the head entry (PC of the instruction, not of its prefix)
- yumi_i  in  1  consumer takes the head entry; legal only when v_o=1

## Operation
- A word is accepted when inst_v_i & inst_ready_o & ~flush_i.
- Prefix word, identified by the top 5 bits equal to PREFIX_OP_P:
  - Latch payload P = inst_i[WORD_SIZE_P-6:0] and set the pending flag.
  - No FIFO entry is written.
  - A second prefix while one is pending overwrites P; the last prefix wins.
- Non-prefix word:
  - Decode combinationally through the ROM and the dest, src1 and src2/imm muxes.
  - bcc_op = inst_i[11:8].
  - Write {decoded, ext_v, pc_i} to the FIFO tail.
  - The pending flag is cleared on the same edge.
- Extension rule:
  - Applies if the pending flag is set and the ROM selects any immediate source (src_2_imm_sel ≠ register).
  - Then source2_imm = {P, inst_i[4:0]} and ext_v=1.
  - If the selection is a register, P is discarded and ext_v=0.
  - Without a pending prefix, ext_v=0 and the normal mux output is used.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count of 0..FIFO_DEPTH_P.
  - A pointer wraps to 0 after FIFO_DEPTH_P-1.
  - Enqueue and dequeue in the same cycle leave the count unchanged.
- Derived outputs:
  - inst_ready_o = (count < FIFO_DEPTH_P). It does not depend on yumi_i (no combinational ready path).
  - v_o = (count ≠ 0).
  - o, ext_v_o and pc_o are driven from the head entry.
- Flush:
  - On an edge with flush_i=1, count, both pointers and the pending flag go to 0.
  - An accept or yumi presented in the same cycle is ignored.
- yumi_i with v_o=0 is illegal; the FIFO must not underflow (count holds at 0).
- Reset (reset_n_i low, any time, asynchronous):
  - Pointers, count, pending flag, P and all FIFO storage clear to 0.
  - Outputs: v_o=0, inst_ready_o=1, o=0, ext_v_o=0, pc_o=0.
  - Reset mid-operation drops all in-flight entries and any pending prefix.

## Timing
- Latency: a word accepted at edge N appears at the head with v_o=1 after edge N if the FIFO was empty. Otherwise it appears after the older entries are dequeued.
- A prefix plus its instruction takes two accepted words and produces one entry.
- Throughput: one instruction per cycle with FIFO_DEPTH_P ≥ 2 and the consumer asserting yumi_i every cycle v_o=1.
- Full: inst_ready_o drops the cycle after the count reaches FIFO_DEPTH_P. It returns the cycle after a dequeue.
- The head outputs are register/mux outputs only, with no path from inst_i to o.
- Release of reset_n_i is synchronous to clk_i upstream; the first accept may occur on the first edge after release.

## Test plan
- Reset with random garbage on the inputs: v_o=0, inst_ready_o=1, o=0, ext_v_o=0, pc_o=0 both during reset and after release.
- Stream 8 non-prefix words with yumi_i held at 1: v_o stays high from the cycle after the first accept, pc_o follows 0x0000..0x000E in order, and there are no bubbles.
- Prefix 0xF7FF at pc 0x0010, then an imm_5z instruction with inst_i[4:0]=5'h15 at pc 0x0012: exactly one entry, source2_imm=0xFFF5, ext_v_o=1, pc_o=0x0012.
- Prefix 0xF001, then prefix 0xF002, then an imm instruction with low bits 0x03: source2_imm=0x0043. A following imm instruction without a prefix has ext_v_o=0 and uses the unmodified mux value.
- Hold yumi_i=0 and present 4 words with FIFO_DEPTH_P=2: exactly 2 are accepted and inst_ready_o=0. Then pulse yumi_i once: inst_ready_o=1 on the next cycle and the third word enters. The pointers wrap with the order preserved.
- Assert flush_i with 2 entries buffered and a prefix pending, while inst_v_i and yumi_i are high in the same cycle: next cycle v_o=0 and count is 0, and the next imm instruction has ext_v_o=0. Repeat the scenario with reset_n_i pulsed low mid-stream instead of flush_i, with the same result.
